mvu_pe_acc: RTL and testbench

// - Accumulates the per-cycle SIMD-sum from the PE adder tree across the SF = MatrixW/SIMD

---
 rtl/mvau_defn.sv | 20 ++
 rtl/mvu_pe_acc.sv | 88 ++++++++
 tb/tb_mvu_pe_acc.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mvau_defn.sv
// Shared MVAU dimensioning: data width, SIMD lanes, and matrix width.
// Helpers derive the per-neuron fold count and the width of its counter.
package mvau_defn;

    localparam int TDstI   = 16;
    localparam int SIMD    = 2;
    localparam int MatrixW = 8;

    function automatic int calc_sf(input int matrix_w, input int simd);
        return matrix_w / simd;
    endfunction

    function automatic int calc_cw(input int sf);
        return (sf > 1) ? $clog2(sf) : 1;
    endfunction

    localparam int SF = calc_sf(MatrixW, SIMD);
    localparam int CW = calc_cw(SF);

endpackage

// File: rtl/mvu_pe_acc.sv
// Per-PE fold accumulator: sums SF adder-tree beats into one dot product per neuron,
// behind a single-entry valid/ready output register.
module mvu_pe_acc
    import mvau_defn::calc_sf;
    import mvau_defn::calc_cw;
#(
    parameter int TDstI   = mvau_defn::TDstI,
    parameter int SIMD    = mvau_defn::SIMD,
    parameter int MatrixW = mvau_defn::MatrixW
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic [TDstI-1:0] in_add,
    input  logic             in_v,
    output logic             in_rdy,
    output logic [TDstI-1:0] out_acc,
    output logic             out_v,
    input  logic             out_rdy
);

    localparam int SF = calc_sf(MatrixW, SIMD);
    localparam int CW = calc_cw(SF);
    localparam logic [CW-1:0] LAST_FOLD = CW'(SF - 1);

    logic [CW-1:0]    fold_cnt_q, fold_cnt_d;
    logic [TDstI-1:0] acc_q, acc_d;
    logic [TDstI-1:0] out_acc_q, out_acc_d;
    logic             out_v_q, out_v_d;

    logic accept;
    logic first_fold;
    logic last_fold;
    logic [TDstI-1:0] sum;

    // The output register is a one-entry skid: it frees up in the same cycle it drains.
    assign in_rdy = !out_v_q || out_rdy;

    assign accept     = in_v && in_rdy;
    assign first_fold = (fold_cnt_q == '0);
    assign last_fold  = (fold_cnt_q == LAST_FOLD);
    // Fold 0 ignores the stale partial sum, which also covers SF==1.
    assign sum        = first_fold ? in_add : acc_q + in_add;

    // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fold_cnt_d = fold_cnt_q;
        acc_d      = acc_q;
        out_acc_d  = out_acc_q;
        out_v_d    = out_v_q;

        if (accept) begin
            fold_cnt_d = last_fold ? '0 : fold_cnt_q + 1'b1;
            acc_d      = sum;
        end

        if (accept && last_fold) begin
            out_acc_d = sum;
            out_v_d   = 1'b1;
        end else if (out_rdy) begin
            out_v_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) fold_cnt_q <= '0;
        else     fold_cnt_q <= fold_cnt_d;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            out_acc_q <= '0;
            out_v_q   <= 1'b0;
        end else begin
            out_acc_q <= out_acc_d;
            out_v_q   <= out_v_d;
        end
    end

    assign out_acc = out_acc_q;
    assign out_v   = out_v_q;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Directed bench for mvu_pe_acc: an SF=4 instance for the main scenarios and an
// SF=1 instance for the every-cycle result case.
module tb_mvu_pe_acc;

    localparam int W = 16;

    logic         aclk = 1'b0;
    logic         rst;

    logic [W-1:0] in_add,  in_add1;
    logic         in_v,    in_v1;
    logic         in_rdy,  in_rdy1;
    logic [W-1:0] out_acc, out_acc1;
    logic         out_v,   out_v1;
    logic         out_rdy, out_rdy1;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    mvu_pe_acc #(.TDstI(W), .SIMD(2), .MatrixW(8)) dut (
        .aclk    (aclk),
        .rst     (rst),
        .in_add  (in_add),
        .in_v    (in_v),
        .in_rdy  (in_rdy),
        .out_acc (out_acc),
        .out_v   (out_v),
        .out_rdy (out_rdy)
    );

    mvu_pe_acc #(.TDstI(W), .SIMD(2), .MatrixW(2)) dut1 (
        .aclk    (aclk),
        .rst     (rst),
        .in_add  (in_add1),
        .in_v    (in_v1),
        .in_rdy  (in_rdy1),
        .out_acc (out_acc1),
        .out_v   (out_v1),
        .out_rdy (out_rdy1)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one input, then wait for the edge and sample 1 time unit after it.
    task automatic beat(input logic v, input logic [W-1:0] val);
        in_v   = v;
        in_add = val;
        @(posedge aclk);
        #1;
    endtask

    task automatic beat1(input logic v, input logic [W-1:0] val);
        in_v1   = v;
        in_add1 = val;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_v", 32'(out_v), 32'd0);
        @(posedge aclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_add   = '0;
        in_v     = 1'b0;
        out_rdy  = 1'b1;
        in_add1  = '0;
        in_v1    = 1'b0;
        out_rdy1 = 1'b1;

        // Reset state
        #2;
        check("reset_out_v",   32'(out_v),   32'd0);
        check("reset_out_acc", 32'(out_acc), 32'd0);
        check("reset_in_rdy",  32'(in_rdy),  32'd1);
        @(posedge aclk);
        #1;
        rst = 1'b0;

        // Basic: 1,2,3,4 -> 10 one cycle after the 4th beat, for exactly one cycle
        beat(1'b1, 16'd1);  check("basic_v0", 32'(out_v), 32'd0);
        beat(1'b1, 16'd2);  check("basic_v1", 32'(out_v), 32'd0);
        beat(1'b1, 16'd3);  check("basic_v2", 32'(out_v), 32'd0);
        beat(1'b1, 16'd4);
        check("basic_v3",   32'(out_v),   32'd1);
        check("basic_acc",  32'(out_acc), 32'd10);
        beat(1'b0, 16'd0);
        check("basic_drain", 32'(out_v), 32'd0);

        // Back-to-back: 10 then 20 four cycles apart, in_rdy always 1
        beat(1'b1, 16'd1);
        beat(1'b1, 16'd2);
        beat(1'b1, 16'd3);
        beat(1'b1, 16'd4);
        check("b2b_v_a",   32'(out_v),   32'd1);
        check("b2b_acc_a", 32'(out_acc), 32'd10);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 16'd5);
            check("b2b_rdy_mid", 32'(in_rdy), 32'd1);
            check("b2b_v_mid",   32'(out_v),  32'd0);
        end
        beat(1'b1, 16'd5);
        check("b2b_v_b",   32'(out_v),   32'd1);
        check("b2b_acc_b", 32'(out_acc), 32'd20);
        beat(1'b0, 16'd0);
        check("b2b_drain", 32'(out_v), 32'd0);

        // Back-pressure: 10 held, next neuron's beats stalled, none lost
        beat(1'b1, 16'd1);
        beat(1'b1, 16'd2);
        beat(1'b1, 16'd3);
        beat(1'b1, 16'd4);
        check("bp_acc_first", 32'(out_acc), 32'd10);
        out_rdy = 1'b0;
        in_v    = 1'b1;
        in_add  = 16'd5;
        #1;
        check("bp_in_rdy_low", 32'(in_rdy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 16'd5);
            check("bp_hold_v",   32'(out_v),   32'd1);
            check("bp_hold_acc", 32'(out_acc), 32'd10);
        end
        out_rdy = 1'b1;
        beat(1'b1, 16'd5);
        check("bp_drained", 32'(out_v), 32'd0);
        beat(1'b1, 16'd5);
        beat(1'b1, 16'd5);
        check("bp_not_early", 32'(out_v), 32'd0);
        beat(1'b1, 16'd5);
        check("bp_v_second",   32'(out_v),   32'd1);
        check("bp_acc_second", 32'(out_acc), 32'd20);
        beat(1'b0, 16'd0);

        // Wrap: 7FFF+1 -> 8000; -1 x4 -> FFFC
        beat(1'b1, 16'h7FFF);
        beat(1'b1, 16'h0001);
        beat(1'b1, 16'h0000);
        beat(1'b1, 16'h0000);
        check("wrap_pos", 32'(out_acc), 32'h8000);
        for (int i = 0; i < 4; i++) beat(1'b1, 16'hFFFF);
        check("wrap_neg", 32'(out_acc), 32'hFFFC);
        beat(1'b0, 16'd0);

        // Gaps: valid pattern 1,0,1,0,1,1 with junk on idle cycles
        beat(1'b1, 16'd1);
        beat(1'b0, 16'hAAAA);
        beat(1'b1, 16'd2);
        beat(1'b0, 16'hAAAA);
        beat(1'b1, 16'd3);
        check("gap_not_done", 32'(out_v), 32'd0);
        beat(1'b1, 16'd4);
        check("gap_v",   32'(out_v),   32'd1);
        check("gap_acc", 32'(out_acc), 32'd10);
        beat(1'b0, 16'd0);

        // Mid-neuron reset discards the partial 7+7
        beat(1'b1, 16'd7);
        beat(1'b1, 16'd7);
        in_v = 1'b0;
        do_reset();
        check("post_rst_v", 32'(out_v), 32'd0);
        for (int i = 0; i < 3; i++) beat(1'b1, 16'd1);
        check("rst_not_early", 32'(out_v), 32'd0);
        beat(1'b1, 16'd1);
        check("rst_v",   32'(out_v),   32'd1);
        check("rst_acc", 32'(out_acc), 32'd4);
        beat(1'b0, 16'd0);

        // SF=1: 3,-1,9 emerge on consecutive cycles with out_v steady
        beat1(1'b1, 16'd3);
        check("sf1_v_a",   32'(out_v1),   32'd1);
        check("sf1_acc_a", 32'(out_acc1), 32'd3);
        check("sf1_rdy_a", 32'(in_rdy1),  32'd1);
        beat1(1'b1, 16'hFFFF);
        check("sf1_v_b",   32'(out_v1),   32'd1);
        check("sf1_acc_b", 32'(out_acc1), 32'hFFFF);
        beat1(1'b1, 16'd9);
        check("sf1_v_c",   32'(out_v1),   32'd1);
        check("sf1_acc_c", 32'(out_acc1), 32'd9);
        beat1(1'b0, 16'd0);
        check("sf1_drain", 32'(out_v1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
